// File: rtl/lc4_mem_pkg.sv
// lc4_mem_pkg: shared definitions for the LC4 data-memory path.
// Holds the MMIO window base, the store-buffer FSM encoding and the
// record kept per buffered store.
package lc4_mem_pkg;

  // Addresses at or above this value are device registers, never buffered.
  localparam logic [15:0] LC4_MMIO_BASE = 16'hFE00;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } sb_entry_t;

endpackage

// File: rtl/lc4_store_buffer_if.sv
// lc4_store_buffer_if: M-stage request bus plus the data-memory port.
// master = pipeline/memory side, slave = the store buffer.
interface lc4_store_buffer_if;

  logic        gwe;
  logic        i_st_valid;
  logic        i_ld_valid;
  logic [15:0] i_addr;
  logic [15:0] i_st_data;
  logic        i_flush;
  logic [15:0] o_ld_data;
  logic        o_stall;
  logic [15:0] o_mem_addr;
  logic        o_mem_we;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        o_empty;

  modport master (
    output gwe,
    output i_st_valid,
    output i_ld_valid,
    output i_addr,
    output i_st_data,
    output i_flush,
    output i_mem_rdata,
    input  o_ld_data,
    input  o_stall,
    input  o_mem_addr,
    input  o_mem_we,
    input  o_mem_wdata,
    input  o_empty
  );

  modport slave (
    input  gwe,
    input  i_st_valid,
    input  i_ld_valid,
    input  i_addr,
    input  i_st_data,
    input  i_flush,
    input  i_mem_rdata,
    output o_ld_data,
    output o_stall,
    output o_mem_addr,
    output o_mem_we,
    output o_mem_wdata,
    output o_empty
  );

endinterface

// File: rtl/lc4_sb_match.sv
// lc4_sb_match: finds the youngest valid buffer entry whose address equals
// addr_i. Valid entries are the count_i slots starting at head_i (oldest)
// and wrapping modulo DEPTH.
module lc4_sb_match #(
  parameter int DEPTH = 4
) (
  input  logic [15:0]              addrs_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic [15:0]              addr_i,
  output logic                     hit_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] slot;

  // Walk oldest to youngest; a later match overwrites an earlier one.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_i + PW'(k);
      if ((k < int'(count_i)) && (addrs_i[slot] == addr_i)) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/lc4_store_buffer.sv
// lc4_store_buffer: posted-store FIFO between the LC4 M stage and the
// single-port data memory. Stores retire in order whenever no load needs
// the port; MMIO stores and flush requests drain the buffer first.
// Build option LC4_SB_FORWARD_EN: when defined, loads forward from the
// youngest matching entry; otherwise a matching load stalls until the
// matching store has retired, then reads memory.
module lc4_store_buffer
  import lc4_mem_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] MMIO_BASE = LC4_MMIO_BASE
) (
  input logic               clk,
  input logic               rst,
  lc4_store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_state_e     state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sb_entry_t     entries_q [DEPTH];
  logic [15:0]   entry_addr [DEPTH];

  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          st_mmio;
  logic          ld_mmio;
  logic          ld_hit;
  logic          not_empty;
  logic          last_entry;

  logic          stall;
  logic          ld_svc;
  logic          do_deq;
  logic          do_enq;
  logic          wt;

  // Address view of the entries for the match finder.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = entries_q[i].addr;
    end
  end

  lc4_sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .addrs_i (entry_addr),
    .head_i  (head_q),
    .count_i (count_q),
    .addr_i  (bus.i_addr),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

  assign st_mmio    = bus.i_st_valid && (bus.i_addr >= MMIO_BASE);
  assign ld_mmio    = bus.i_ld_valid && (bus.i_addr >= MMIO_BASE);
  assign ld_hit     = bus.i_ld_valid && !ld_mmio && hit;
  assign not_empty  = (count_q != '0);
  assign last_entry = (count_q == CW'(1));

  // Next state, stall and memory-port arbitration. While rst is low the
  // port is held idle so nothing pending leaks out during reset.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    ld_svc  = 1'b0;
    do_deq  = 1'b0;
    do_enq  = 1'b0;
    wt      = 1'b0;
    if (rst) begin
      case (state_q)
        RUN: begin
          if (bus.i_flush && not_empty) begin
            stall = 1'b1;
            // A single entry drains this cycle, so FLUSH would be empty.
            if (!last_entry) state_d = FLUSH;
          end else if (st_mmio && not_empty) begin
            stall = 1'b1;
          end
`ifndef LC4_SB_FORWARD_EN
          else if (ld_hit) begin
            stall = 1'b1;
          end
`endif
          ld_svc = bus.i_ld_valid && !stall;
          // Loads and stores are exclusive, so a store cycle always drains
          // the head; that frees a slot for a store arriving at a full FIFO.
          do_deq = !ld_svc && not_empty;
          do_enq = bus.i_st_valid && !st_mmio && !stall;
          wt     = st_mmio && !stall;
        end
        FLUSH: begin
          stall  = 1'b1;
          do_deq = not_empty;
          if (count_q <= CW'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Pointer and occupancy updates.
  always_comb begin
    head_d  = do_deq ? head_q + PW'(1) : head_q;
    tail_d  = do_enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(do_enq) - CW'(do_deq);
  end

  // Control registers; every update waits for gwe, including reset.
  always_ff @(posedge clk) begin
    if (bus.gwe) begin
      if (!rst) begin
        state_q <= RUN;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        state_q <= state_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end
  end

  // Entry storage; validity comes from head/count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (bus.gwe && do_enq) begin
      entries_q[tail_q] <= '{addr: bus.i_addr, data: bus.i_st_data};
    end
  end

  // Data-memory port drive: load read, head retire, or MMIO write-through.
  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_wdata = '0;
    if (ld_svc) begin
      bus.o_mem_addr = bus.i_addr;
    end else if (do_deq) begin
      bus.o_mem_addr  = entries_q[head_q].addr;
      bus.o_mem_we    = bus.gwe;
      bus.o_mem_wdata = entries_q[head_q].data;
    end else if (wt) begin
      bus.o_mem_addr  = bus.i_addr;
      bus.o_mem_we    = bus.gwe;
      bus.o_mem_wdata = bus.i_st_data;
    end
  end

`ifdef LC4_SB_FORWARD_EN
  // Youngest matching entry wins over memory.
  assign bus.o_ld_data = ld_hit ? entries_q[hit_idx].data : bus.i_mem_rdata;
`else
  logic sb_unused_idx;
  assign sb_unused_idx = ^hit_idx;
  // Matching loads stall instead, so memory always holds the right value.
  assign bus.o_ld_data = bus.i_mem_rdata;
`endif

  assign bus.o_stall = stall;
  assign bus.o_empty = !not_empty;

endmodule

// File: tb/tb_lc4_store_buffer.sv
// tb_lc4_store_buffer: directed scenarios and random traffic against a
// queue-based reference of the store buffer and a memory image.
module tb_lc4_store_buffer;

  logic clk = 1'b0;
  logic rst;

  lc4_store_buffer_if bus ();

  lc4_store_buffer #(
    .DEPTH     (4),
    .MMIO_BASE (16'hFE00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];

  assign bus.i_mem_rdata = mem[bus.o_mem_addr];

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } st_t;

  st_t pend[$];
  bit  flushing = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // Field order: stall, mem_we, mem_addr, mem_wdata, ld_data, empty.
  logic [50:0] act_vec;
  logic [50:0] exp_vec;
  bit          exp_stall;

  task automatic cycle(input bit st, input bit ld, input bit fl,
                       input logic [15:0] a, input logic [15:0] d,
                       input bit r, input bit g);
    int          n;
    bit          mm, hit, pop, push, wt, port_ld, enter, e_we;
    logic [15:0] fwd, e_addr, e_wdata, e_ld;
    @(negedge clk);
    rst            = r;
    bus.gwe        = g;
    bus.i_st_valid = st;
    bus.i_ld_valid = ld;
    bus.i_flush    = fl;
    bus.i_addr     = a;
    bus.i_st_data  = d;
    #1;
    n   = pend.size();
    mm  = (a >= 16'hFE00);
    hit = 1'b0;
    fwd = '0;
    foreach (pend[i]) if (pend[i].a == a) begin hit = 1'b1; fwd = pend[i].d; end
    exp_stall = 1'b0; pop = 1'b0; push = 1'b0; wt = 1'b0; port_ld = 1'b0;
    if (r) begin
      exp_stall = flushing || (fl && n > 0) || (st && mm && n > 0);
`ifndef LC4_SB_FORWARD_EN
      if (ld && !mm && hit) exp_stall = 1'b1;
`endif
      if (ld && !exp_stall) port_ld = 1'b1;
      else if (n > 0) pop = 1'b1;
      else if (st && mm && !exp_stall) wt = 1'b1;
      push = st && !mm && !exp_stall;
    end
    e_addr  = (port_ld || wt) ? a : (pop ? pend[0].a : 16'h0000);
    e_wdata = wt ? d : (pop ? pend[0].d : 16'h0000);
    e_we    = (pop || wt) && g;
    e_ld    = ref_mem[e_addr];
`ifdef LC4_SB_FORWARD_EN
    if (ld && !mm && hit) e_ld = fwd;
`endif
    exp_vec = {exp_stall, e_we, e_addr, e_wdata, e_ld, (n == 0)};
    act_vec = {bus.o_stall, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata,
               bus.o_ld_data, bus.o_empty};
    @(posedge clk);
    if (act_vec[49]) mem[act_vec[48:33]] = act_vec[32:17];
    if (g) begin
      if (!r) begin
        pend.delete();
        flushing = 1'b0;
      end else begin
        enter = flushing || (fl && n > 0);
        if (pop) begin
          ref_mem[pend[0].a] = pend[0].d;
          void'(pend.pop_front());
        end
        if (wt) ref_mem[a] = d;
        if (push) pend.push_back('{a: a, d: d});
        flushing = enter && (pend.size() > 0);
      end
    end
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    cycle(0, 0, 0, 16'h0000, 16'h0000, 1, 1);
    n_chk++;
    if (act_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL reset_model: got %h expected %h", act_vec, exp_vec);
    end
    n_chk++;
    if ({act_vec[50:17], act_vec[0]} !== {34'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall/we/addr/wdata/empty %h expected %h",
               {act_vec[50:17], act_vec[0]}, {34'h0, 1'b1});
    end
    n_chk++;
    if (act_vec[16:1] !== mem[16'h0000]) begin
      n_fail++;
      $display("FAIL reset_ld_data: got %h expected %h", act_vec[16:1], mem[16'h0000]);
    end
  endtask

  task automatic test_store_drain();
    logic [15:0] sa [5] = '{16'h4000, 16'h4001, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] sd [5] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      cycle(i < 2, 0, 0, sa[i], sd[i], 1, 1);
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL store_drain cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
    end
    n_chk++;
    if (act_vec[0] !== 1'b1 || mem[16'h4000] !== 16'h1111 || mem[16'h4001] !== 16'h2222) begin
      n_fail++;
      $display("FAIL store_drain_final: got empty %b m4000 %h m4001 %h expected 1 1111 2222",
               act_vec[0], mem[16'h4000], mem[16'h4001]);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 16'h4010 + 16'(i), 16'($urandom), 1, 1);
      n_chk++;
      if (act_vec !== exp_vec || act_vec[50] !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_back st %0d: got %h expected %h", i, act_vec, exp_vec);
      end
    end
    guard = 0;
    while (pend.size() > 0 && guard < 10) begin
      cycle(0, 0, 0, 16'h0000, 16'h0000, 1, 1);
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL back_to_back drain: got %h expected %h", act_vec, exp_vec);
      end
      guard++;
    end
    n_chk++;
    if (pend.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back timeout: got %0d pending expected 0", pend.size());
    end
  endtask

  task automatic test_forward();
    int guard;
    cycle(1, 0, 0, 16'h4000, 16'hAAAA, 1, 1);
    cycle(1, 0, 0, 16'h4000, 16'hBBBB, 1, 1);
    guard = 0;
    do begin
      cycle(0, 1, 0, 16'h4000, 16'h0000, 1, 1);
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL forward cyc %0d: got %h expected %h", guard, act_vec, exp_vec);
      end
      guard++;
    end while (exp_stall && guard < 20);
    n_chk++;
    if (act_vec[16:1] !== 16'hBBBB || exp_stall) begin
      n_fail++;
      $display("FAIL forward_data: got %h expected bbbb", act_vec[16:1]);
    end
  endtask

  task automatic test_mmio();
    int guard;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h4020 + 16'(i), 16'h7000 + 16'(i), 1, 1);
    guard = 0;
    do begin
      cycle(1, 0, 0, 16'hFE02, 16'h5A5A, 1, 1);
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL mmio cyc %0d: got %h expected %h", guard, act_vec, exp_vec);
      end
      guard++;
    end while (exp_stall && guard < 20);
    n_chk++;
    if (act_vec[50:17] !== {1'b0, 1'b1, 16'hFE02, 16'h5A5A} || exp_stall) begin
      n_fail++;
      $display("FAIL mmio_writethrough: got %h expected %h",
               act_vec[50:17], {1'b0, 1'b1, 16'hFE02, 16'h5A5A});
    end
  endtask

  task automatic test_flush();
    int guard;
    cycle(1, 0, 0, 16'h4030, 16'h3030, 1, 1);
    cycle(1, 0, 0, 16'h4031, 16'h3131, 1, 1);
    guard = 0;
    do begin
      cycle(0, 0, 1, 16'h0000, 16'h0000, 1, 1);
      n_chk++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL flush cyc %0d: got %h expected %h", guard, act_vec, exp_vec);
      end
      guard++;
    end while (exp_stall && guard < 20);
    n_chk++;
    if (act_vec[50] !== 1'b0 || act_vec[0] !== 1'b1 || flushing) begin
      n_fail++;
      $display("FAIL flush_done: got stall %b empty %b expected 0 1", act_vec[50], act_vec[0]);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 16'h4040, 16'h4444, 1, 1);
    cycle(1, 0, 0, 16'h4041, 16'h4545, 1, 1);
    cycle(0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 16'h0000, 16'h0000, 1, 1);
      n_chk++;
      if (act_vec !== exp_vec || act_vec[49] !== 1'b0 || act_vec[48:33] !== 16'h0000
          || act_vec[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_gwe();
    cycle(1, 0, 0, 16'h4050, 16'h5050, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(i == 1, 0, 0, 16'h4051, 16'h5151, 1, 0);
      n_chk++;
      if (act_vec !== exp_vec || act_vec[49] !== 1'b0) begin
        n_fail++;
        $display("FAIL gwe_hold cyc %0d: got %h expected %h", i, act_vec, exp_vec);
      end
    end
    cycle(0, 0, 0, 16'h0000, 16'h0000, 1, 1);
    n_chk++;
    if (act_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL gwe_resume: got %h expected %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [6] = '{16'h4000, 16'h4001, 16'h4002, 16'h4003, 16'hFE00, 16'hFE02};
    int          op, guard;
    logic [15:0] a, d;
    bit          g;
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 4);
      a  = pool[$urandom_range(0, 5)];
      d  = 16'($urandom);
      g  = ($urandom_range(0, 9) != 0);
      guard = 0;
      do begin
        cycle(op == 1 || op == 4, op == 2, op == 3, a, d, 1, (guard == 0) ? g : 1'b1);
        n_chk++;
        if (act_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL random op %0d it %0d: got %h expected %h", op, k, act_vec, exp_vec);
        end
        guard++;
      end while (exp_stall && guard < 40);
      if (exp_stall) begin
        n_chk++;
        n_fail++;
        $display("FAIL random stall_timeout it %0d: got stall 1 expected 0", k);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i) ^ 16'hA5C3;
      ref_mem[i] = 16'(i) ^ 16'hA5C3;
    end
    rst            = 1'b0;
    bus.gwe        = 1'b1;
    bus.i_st_valid = 1'b0;
    bus.i_ld_valid = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_addr     = '0;
    bus.i_st_data  = '0;
    test_reset();
    test_store_drain();
    test_back_to_back();
    test_forward();
    test_mmio();
    test_flush();
    test_reset_mid();
    test_gwe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
